spi_txn_arbiter: RTL
====================

Name: spi_txn_arbiter

Overview:
- Shares one SPI master between NUM_REQ independent requesters, e.g. CPU port, sensor poller and flash loader.
- Sits between the requesters and the master's host-side control interface (start / host_out / host_in / busy / done).
- Picks requesters round-robin and issues one DATA_LENGTH-bit transfer per grant.
- Returns the received word to the winner and drives a one-hot slave-select vector, which gates the master's single spi_cs_n onto per-slave chip-select lines.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DATA_LENGTH, 8: SPI word width; must equal the master's DATA_LENGTH.
- TIMEOUT_CYCLES, 1024: clk cycles allowed from m_start to m_done before an error response.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request, level; held until ack.
- req_data  in  NUM_REQ*DATA_LENGTH  tx word; requester i uses slice [i*DATA_LENGTH +: DATA_LENGTH].
- ack  out  NUM_REQ  one-cycle pulse: request i accepted, tx word latched.
- rsp_valid  out  NUM_REQ  one-cycle pulse: response for requester i.
- rsp_data  out  DATA_LENGTH  rx word, valid while rsp_valid is nonzero.
- rsp_err  out  1  timeout flag, valid with rsp_valid.
- slave_sel  out  NUM_REQ  one-hot index of the current owner; 0 when idle.
- m_start  out  1  start pulse to the master.
- m_host_out  out  DATA_LENGTH  tx word to the master.
- m_host_in  in  DATA_LENGTH  rx word from the master, valid with m_done.
- m_busy  in  1  master busy.
- m_done  in  1  master done pulse.

Behaviour:
- All outputs are registered.
- Reset values: ack=0, rsp_valid=0, rsp_data=0, rsp_err=0, slave_sel=0, m_start=0, m_host_out=0, rr_ptr=0, state=IDLE, timer=0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Condition to leave: |req && !m_busy && !m_done.
  - Winner = first set req bit scanning upward from rr_ptr, with wrap-around.
  - Same edge: latch winner index, m_host_out <= winner's slice, ack[winner] pulses, slave_sel <= onehot(winner), go to ISSUE.
  - Otherwise stay, all pulses 0.
- ISSUE:
  - m_start=1 for exactly one cycle; timer cleared; go to WAIT.
  - m_host_out is held stable from ISSUE until leaving WAIT.
- WAIT:
  - timer increments each cycle.
  - On m_done: rsp_data <= m_host_in, rsp_err <= 0, go to RESP.
  - Else if timer == TIMEOUT_CYCLES-1: rsp_data <= 0, rsp_err <= 1, go to RESP.
  - m_done takes priority over a simultaneous timeout.
- RESP:
  - rsp_valid[owner] pulses one cycle.
  - rr_ptr <= owner+1, wrapping at NUM_REQ.
  - slave_sel <= 0; go to IDLE.
- Latency: req sampled at cycle 0 gives ack at cycle 1 and m_start at cycle 2. m_done at cycle k gives rsp_valid at cycle k+2.
- Back-to-back transfers: the next m_start cannot occur before 2 cycles after RESP. The !m_busy && !m_done gate guarantees the master is in IDLE.
- rr_ptr advances only on completion, so one requester cannot be granted twice while another requester is waiting.
- req deasserted before ack: no effect.
- req dropped after ack: the transfer still completes and the response is still pulsed.
- After a timeout the master may still be busy. IDLE's !m_busy gate prevents overlapping transfers. A late m_done arriving while in IDLE is ignored.
- m_done seen outside WAIT: ignored.
- Reset mid-transfer: all state is cleared asynchronously. No response is issued.
- NUM_REQ is not a power of two: the scan is over valid indices only, with wrap at NUM_REQ.

Decomposition:
- Package spi_pkg holds:
  - arb_state_t (enum bit [1:0]: IDLE, ISSUE, WAIT, RESP);
  - the function onehot(idx, n);
  - the localparam width helper $clog2(NUM_REQ).
- One sub-module, spi_rr_pick.
  - Purely combinational priority scan: inputs req and rr_ptr; outputs valid and winner index.
  - Instantiated once.

Test Plan:
- Single request: NUM_REQ=4, req=4'b0100, req_data slice2=8'hA5, master model returns 8'h3C:
  - ack=4'b0100 at cycle 1; m_start at cycle 2 with m_host_out=8'hA5; slave_sel=4'b0100;
  - rsp_valid=4'b0100, rsp_data=8'h3C, rsp_err=0.
- Round-robin: req=4'b1111 held, each requester re-asserts after its rsp:
  - grant order 0,1,2,3,0; exactly one m_start per transfer; no overlap with m_busy.
- Starvation check: req0 continuously high, req3 raised once:
  - req3 is granted no later than the second completion after it rises.
- Timeout: TIMEOUT_CYCLES=16, master never returns done:
  - rsp_valid pulses 17 cycles after m_start with rsp_err=1 and rsp_data=8'h00;
  - no new m_start until m_busy is 0.
- Done/timeout collision: m_done asserted on the cycle timer reaches 15:
  - rsp_err=0 and rsp_data = m_host_in.
- Reset mid-WAIT: rst_n low for 3 cycles during a transfer:
  - all outputs 0 immediately; no rsp_valid after release;
  - the next request is served from rr_ptr=0.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared types and helpers for the SPI transaction arbiter.
package spi_pkg;

   typedef enum bit [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

   localparam int MAX_REQ = 8;

   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic logic [MAX_REQ-1:0] onehot(input int idx, input int n);
      return (idx < n) ? MAX_REQ'(1) << idx : '0;
   endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// spi_rr_pick: combinational round-robin scan, first set request at or above ptr_i with wrap.
module spi_rr_pick
   import spi_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IW      = idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IW-1:0]      ptr_i,
   output logic               valid_o,
   output logic [IW-1:0]      winner_o
);

   int j;

   // Scanning from the far end lets the nearest index to ptr_i overwrite the rest.
   always_comb begin
      valid_o  = |req_i;
      winner_o = '0;
      j        = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         j = (int'(ptr_i) + k) % NUM_REQ;
         if (req_i[j]) winner_o = IW'(j);
      end
   end

endmodule

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin sharing of one SPI master between NUM_REQ requesters,
// one transfer per grant with timeout and per-slave select.
module spi_txn_arbiter
   import spi_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int DATA_LENGTH    = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ*DATA_LENGTH-1:0] req_data,
   output logic [NUM_REQ-1:0]             ack,
   output logic [NUM_REQ-1:0]             rsp_valid,
   output logic [DATA_LENGTH-1:0]         rsp_data,
   output logic                           rsp_err,
   output logic [NUM_REQ-1:0]             slave_sel,
   output logic                           m_start,
   output logic [DATA_LENGTH-1:0]         m_host_out,
   input  logic [DATA_LENGTH-1:0]         m_host_in,
   input  logic                           m_busy,
   input  logic                           m_done
);

   localparam int IW = idx_w(NUM_REQ);
   localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

   arb_state_t             state_q, state_d;
   logic [IW-1:0]          owner_q, owner_d, rr_q, rr_d, pick_win;
   logic [TW-1:0]          timer_q, timer_d;
   logic [NUM_REQ-1:0]     ack_q, ack_d, rsp_valid_q, rsp_valid_d, sel_q, sel_d;
   logic [DATA_LENGTH-1:0] rsp_data_q, rsp_data_d, host_q, host_d;
   logic                   rsp_err_q, rsp_err_d, start_q, start_d;
   logic                   pick_valid, grant, done_ev, timeout;

   spi_rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
      .req_i   (req),
      .ptr_i   (rr_q),
      .valid_o (pick_valid),
      .winner_o(pick_win)
   );

   // The done gate keeps a late done from a timed-out transfer out of the next grant.
   assign grant   = state_q == IDLE && pick_valid && !m_busy && !m_done;
   assign done_ev = state_q == WAIT && m_done;
   assign timeout = state_q == WAIT && timer_q == TW'(TIMEOUT_CYCLES - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = grant ? ISSUE : IDLE;
         ISSUE:   state_d = WAIT;
         WAIT:    state_d = (done_ev || timeout) ? RESP : WAIT;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ack_d       = grant ? NUM_REQ'(onehot(int'(pick_win), NUM_REQ)) : '0;
      owner_d     = grant ? pick_win : owner_q;
      host_d      = grant ? req_data[int'(pick_win)*DATA_LENGTH +: DATA_LENGTH] : host_q;
      sel_d       = grant ? NUM_REQ'(onehot(int'(pick_win), NUM_REQ))
                  : (state_q == RESP) ? '0 : sel_q;
      start_d     = state_q == ISSUE;
      timer_d     = (state_q == ISSUE) ? '0 : (state_q == WAIT) ? timer_q + 1'b1 : timer_q;
      rsp_data_d  = done_ev ? m_host_in : timeout ? '0 : rsp_data_q;
      rsp_err_d   = done_ev ? 1'b0 : timeout ? 1'b1 : rsp_err_q;
      rsp_valid_d = (state_q == RESP) ? NUM_REQ'(onehot(int'(owner_q), NUM_REQ)) : '0;
      rr_d        = (state_q != RESP) ? rr_q
                  : (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q     <= '0;
         rr_q        <= '0;
         timer_q     <= '0;
         ack_q       <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         sel_q       <= '0;
         start_q     <= 1'b0;
         host_q      <= '0;
      end else begin
         owner_q     <= owner_d;
         rr_q        <= rr_d;
         timer_q     <= timer_d;
         ack_q       <= ack_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         sel_q       <= sel_d;
         start_q     <= start_d;
         host_q      <= host_d;
      end
   end

   assign ack        = ack_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_err    = rsp_err_q;
   assign slave_sel  = sel_q;
   assign m_start    = start_q;
   assign m_host_out = host_q;

endmodule
